// File: rtl/delay_arb_pkg.sv
// Shared types and round-robin helper for delay_arbiter.
package delay_arb_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_NUM_CNT_BITS = 8;
  localparam int MAX_REQ          = 16;
  localparam int IDX_W            = 4;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit scanning upward from ptr, wrapping at n (n need not be a power of 2).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[IDX_W-1:0]]) begin
          p.vld = 1'b1;
          p.idx = idx[IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover; flag is high while count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? {{(NUM_CNT_BITS-1){1'b0}}, 1'b1} : count_q + 1'b1;
      flag_d  = (count_d == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin sharing of one flex_counter for per-requester programmable waits.
// Optional DELAY_ARB_ABORT_EN: dropping the winner's req during COUNT aborts the job.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] delay,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         count_out
);

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [IDX_W-1:0]        winner_q, winner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_CNT_BITS-1:0] dly_q, dly_d;

  logic [MAX_REQ-1:0]      req_ext;
  pick_t                   pick;
  logic [NUM_CNT_BITS-1:0] sel_dly;
  logic [IDX_W-1:0]        ptr_nxt;
  logic                    clear, cnt_en, roll;

  assign req_ext = MAX_REQ'(req);
  assign pick    = rr_pick(req_ext, ptr_q, NUM_REQ);
  assign ptr_nxt = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

  always_comb begin
    sel_dly = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick.idx == IDX_W'(i)) sel_dly = delay[i*NUM_CNT_BITS +: NUM_CNT_BITS];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    dly_d    = dly_q;
    clear    = 1'b1;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick.vld) begin
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (pick.idx == IDX_W'(i));
          winner_d = pick.idx;
          dly_d    = (sel_dly == '0) ? {{(NUM_CNT_BITS-1){1'b0}}, 1'b1} : sel_dly;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        clear  = 1'b0;
        cnt_en = 1'b1;
`ifdef DELAY_ARB_ABORT_EN
        if (!req_ext[winner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          clear   = 1'b1;
          ptr_d   = ptr_nxt;
        end else
`endif
        if (roll) begin
          // Clear on the final edge so the wrap back to 1 never reaches count_out.
          state_d = DONE;
          grant_d = '0;
          clear   = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) done_d[i] = (winner_q == IDX_W'(i));
        end
      end
      DONE: begin
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      winner_q <= '0;
      ptr_q    <= '0;
      dly_q    <= {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      dly_q    <= dly_d;
    end
  end

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (cnt_en),
    .rollover_val (dly_q),
    .count_out    (count_out),
    .rollover_flag(roll)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule
